// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
// Holds the owner-state enum, the requester IDs and the default burst limit.
package dmem_arb_pkg;

  // Owner state records who received the grant in the previous cycle.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OWN_CORE = 2'd1,
    OWN_HOST = 2'd2
  } ownerState_e;

  // Requester identifiers, used by the last-winner pointer and response routing.
  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  // Default limit on consecutive locked grants to one owner.
  localparam int MAX_BURST_DEFAULT = 16;

  // Width of the burst counter; covers the full legal MAX_BURST range up to 255.
  localparam int BURST_CNT_W = 8;

  // Returns the requester ID matching an owner state. IDLE maps to the core,
  // and callers only use the result when a grant exists.
  function automatic logic ownerToId(input ownerState_e state);
    return (state == OWN_HOST) ? REQ_HOST : REQ_CORE;
  endfunction

endpackage

// File: rtl/dmem_arb_rsp_track.sv
// dmem_arb_rsp_track: read-response tracker for the data-memory arbiter.
// Remembers whether the previous cycle granted a read, and to whom. It then
// steers the memory's registered read data to that requester only.
module dmem_arb_rsp_track
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_readGnt,
  input  logic              i_readId,
  input  logic [DATA_W-1:0] i_memRdata,
  output logic              o_coreRvalid,
  output logic              o_hostRvalid,
  output logic [DATA_W-1:0] o_coreRdata,
  output logic [DATA_W-1:0] o_hostRdata
);

  logic r_rspValid;
  logic r_rspId;

  // Capture every read grant so its response appears exactly one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rspValid <= 1'b0;
      r_rspId    <= REQ_CORE;
    end else begin
      r_rspValid <= i_readGnt;
      if (i_readGnt) begin
        r_rspId <= i_readId;
      end
    end
  end

  // Route the returning data to the requester that issued the read; the other side sees zero.
  always_comb begin
    o_coreRvalid = 1'b0;
    o_hostRvalid = 1'b0;
    o_coreRdata  = '0;
    o_hostRdata  = '0;
    if (r_rspValid) begin
      if (r_rspId == REQ_HOST) begin
        o_hostRvalid = 1'b1;
        o_hostRdata  = i_memRdata;
      end else begin
        o_coreRvalid = 1'b1;
        o_coreRdata  = i_memRdata;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter for the single-port data memory.
// It shares the memory between the core data port and the host loader port.
// Grants are round-robin, single-cycle and combinational. Read responses are
// routed back one cycle later.
// Optional feature: define DMEM_ARB_BURST_EN to let a locked owner keep the
// grant for up to MAX_BURST consecutive transfers.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic              core_lock,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              core_gnt,
  output logic              host_gnt,
  output logic              core_rvalid,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  ownerState_e r_state;
  ownerState_e w_stateNext;
  logic        r_lastWinner;
  logic        w_lastWinnerNext;
  logic        w_holdCore;
  logic        w_holdHost;
  logic        w_readGnt;
  logic        w_readId;

`ifdef DMEM_ARB_BURST_EN
  localparam logic [BURST_CNT_W-1:0] BURST_LIMIT = BURST_CNT_W'(MAX_BURST);

  logic [BURST_CNT_W-1:0] r_burstCnt;
  logic [BURST_CNT_W-1:0] w_burstCntNext;

  // A locked owner keeps the grant only while its run of locked grants is below the limit.
  assign w_holdCore = (r_state == OWN_CORE) && core_lock && (r_burstCnt < BURST_LIMIT);
  assign w_holdHost = (r_state == OWN_HOST) && host_lock && (r_burstCnt < BURST_LIMIT);

  // Count consecutive locked grants: a new owner or a dropped lock restarts the run, and the count saturates at the limit.
  always_comb begin
    w_burstCntNext = '0;
    if (core_gnt && core_lock) begin
      if (r_state == OWN_CORE) begin
        w_burstCntNext = (r_burstCnt == BURST_LIMIT) ? BURST_LIMIT : r_burstCnt + 1'b1;
      end else begin
        w_burstCntNext = BURST_CNT_W'(1);
      end
    end else if (host_gnt && host_lock) begin
      if (r_state == OWN_HOST) begin
        w_burstCntNext = (r_burstCnt == BURST_LIMIT) ? BURST_LIMIT : r_burstCnt + 1'b1;
      end else begin
        w_burstCntNext = BURST_CNT_W'(1);
      end
    end
  end

  // Burst counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_burstCnt <= '0;
    end else begin
      r_burstCnt <= w_burstCntNext;
    end
  end
`else
  logic w_unusedLock;

  // Without burst hold, the lock hints have no effect and arbitration is pure round-robin.
  assign w_unusedLock = core_lock | host_lock;
  assign w_holdCore   = 1'b0;
  assign w_holdHost   = 1'b0;
`endif

  // Owner state and last-winner pointer. The pointer starts at the host so the core wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_lastWinner <= REQ_HOST;
    end else begin
      r_state      <= w_stateNext;
      r_lastWinner <= w_lastWinnerNext;
    end
  end

  // Pick the winner. A lone requester always wins; on contention a burst hold
  // wins first, otherwise the requester that did not win last time.
  always_comb begin
    core_gnt         = 1'b0;
    host_gnt         = 1'b0;
    w_stateNext      = IDLE;
    w_lastWinnerNext = r_lastWinner;
    if (core_req && host_req) begin
      if (w_holdCore) begin
        core_gnt = 1'b1;
      end else if (w_holdHost) begin
        host_gnt = 1'b1;
      end else if (r_lastWinner == REQ_HOST) begin
        core_gnt = 1'b1;
      end else begin
        host_gnt = 1'b1;
      end
    end else if (core_req) begin
      core_gnt = 1'b1;
    end else if (host_req) begin
      host_gnt = 1'b1;
    end
    if (core_gnt) begin
      w_stateNext      = OWN_CORE;
      w_lastWinnerNext = REQ_CORE;
    end else if (host_gnt) begin
      w_stateNext      = OWN_HOST;
      w_lastWinnerNext = REQ_HOST;
    end
  end

  // Drive the memory port from the winner. The port is held at zero whenever no transfer happens.
  always_comb begin
    mem_en    = core_gnt | host_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (host_gnt) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  assign w_readGnt = mem_en & ~mem_we;
  assign w_readId  = host_gnt ? REQ_HOST : ownerToId(OWN_CORE);

  dmem_arb_rsp_track #(
    .DATA_W (DATA_W)
  ) u_rspTrack (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_readGnt    (w_readGnt),
    .i_readId     (w_readId),
    .i_memRdata   (mem_rdata),
    .o_coreRvalid (core_rvalid),
    .o_hostRvalid (host_rvalid),
    .o_coreRdata  (core_rdata),
    .o_hostRdata  (host_rdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter.
// Directed scenarios come first, then randomized traffic. A behavioural memory
// sits on the memory port, and a reference model predicts every grant, memory
// strobe and read response.
module tb_dmem_arbiter;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int MAX_BURST = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              core_req = 1'b0, core_we = 1'b0, core_lock = 1'b0;
  logic [ADDR_W-1:0] core_addr = '0;
  logic [DATA_W-1:0] core_wdata = '0;
  logic              host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic              core_gnt, host_gnt, core_rvalid, host_rvalid;
  logic [DATA_W-1:0] core_rdata, host_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] memRdata = '0;

  int errorCount = 0;
  int checkCount = 0;

  // Model state. Requester IDs are 0 for the core, 1 for the host and 2 for none.
  int                mLast;
  int                mOwner;
  int                mRun;
  bit                mPendValid;
  int                mPendId;
  logic [DATA_W-1:0] mPendData;
  logic [DATA_W-1:0] shadowMem [int];
  logic [DATA_W-1:0] envMem [int];

  dmem_arbiter #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_lock   (core_lock),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_lock   (host_lock),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .core_gnt    (core_gnt),
    .host_gnt    (host_gnt),
    .core_rvalid (core_rvalid),
    .host_rvalid (host_rvalid),
    .core_rdata  (core_rdata),
    .host_rdata  (host_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (memRdata)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Single-port memory with registered read data; its contents survive reset.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        envMem[int'(mem_addr)] = mem_wdata;
      end else begin
        memRdata <= envMem.exists(int'(mem_addr)) ? envMem[int'(mem_addr)] : '0;
      end
    end
  end

  // Count a comparison and report it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at t=%0t", tag, observed, expected, $time);
    end
  endtask

  // Return the model to its post-reset state. Memory contents are untouched.
  task automatic modelReset();
    mLast      = 1;
    mOwner     = 2;
    mRun       = 0;
    mPendValid = 1'b0;
    mPendId    = 0;
    mPendData  = '0;
  endtask

  // Predict this cycle's outputs from the current inputs, compare, then advance the model.
  task automatic modelCheck();
    int                g;
    bit                gLock;
    bit                gWe;
    logic [ADDR_W-1:0] gAddr;
    logic [DATA_W-1:0] gWdata;
    checkOutput("core_rvalid", 32'(core_rvalid), 32'(mPendValid && mPendId == 0));
    checkOutput("host_rvalid", 32'(host_rvalid), 32'(mPendValid && mPendId == 1));
    checkOutput("core_rdata", 32'(core_rdata), (mPendValid && mPendId == 0) ? 32'(mPendData) : 32'h0);
    checkOutput("host_rdata", 32'(host_rdata), (mPendValid && mPendId == 1) ? 32'(mPendData) : 32'h0);
    g = 2;
    if (core_req && host_req) begin
      g = (mLast == 1) ? 0 : 1;
`ifdef DMEM_ARB_BURST_EN
      if (mOwner == 0 && core_lock && mRun < MAX_BURST) g = 0;
      else if (mOwner == 1 && host_lock && mRun < MAX_BURST) g = 1;
`endif
    end else if (core_req) begin
      g = 0;
    end else if (host_req) begin
      g = 1;
    end
    gWe    = (g == 0) ? core_we : (g == 1) ? host_we : 1'b0;
    gLock  = (g == 0) ? core_lock : (g == 1) ? host_lock : 1'b0;
    gAddr  = (g == 0) ? core_addr : (g == 1) ? host_addr : '0;
    gWdata = (g == 0) ? core_wdata : (g == 1) ? host_wdata : '0;
    checkOutput("core_gnt", 32'(core_gnt), 32'(g == 0));
    checkOutput("host_gnt", 32'(host_gnt), 32'(g == 1));
    checkOutput("mem_en", 32'(mem_en), 32'(g != 2));
    checkOutput("mem_we", 32'(mem_we), 32'(gWe));
    checkOutput("mem_addr", 32'(mem_addr), 32'(gAddr));
    checkOutput("mem_wdata", 32'(mem_wdata), 32'(gWdata));
    mPendValid = 1'b0;
    if (g != 2) begin
      mLast = g;
      if (gWe) begin
        shadowMem[int'(gAddr)] = gWdata;
      end else begin
        mPendValid = 1'b1;
        mPendId    = g;
        mPendData  = shadowMem.exists(int'(gAddr)) ? shadowMem[int'(gAddr)] : '0;
      end
      if (gLock) mRun = (mOwner == g) ? ((mRun < MAX_BURST) ? mRun + 1 : MAX_BURST) : 1;
      else mRun = 0;
      mOwner = g;
    end else begin
      mOwner = 2;
      mRun   = 0;
    end
  endtask

  // Drive one cycle of requests just after a rising edge, check at the falling edge, then move to the next cycle.
  task automatic applyStimulus(input logic cReq, input logic cWe, input logic cLock,
                               input logic [ADDR_W-1:0] cAddr, input logic [DATA_W-1:0] cWdata,
                               input logic hReq, input logic hWe, input logic hLock,
                               input logic [ADDR_W-1:0] hAddr, input logic [DATA_W-1:0] hWdata);
    core_req = cReq; core_we = cWe; core_lock = cLock; core_addr = cAddr; core_wdata = cWdata;
    host_req = hReq; host_we = hWe; host_lock = hLock; host_addr = hAddr; host_wdata = hWdata;
    @(negedge clk);
    modelCheck();
    @(posedge clk);
    #1;
  endtask

  // Hold reset low for a number of cycles with the inputs quiet, checking that every output is zero.
  task automatic pulseReset(input int cycles);
    core_req = 1'b0; core_we = 1'b0; core_lock = 1'b0; core_addr = '0; core_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_lock = 1'b0; host_addr = '0; host_wdata = '0;
    reset_n = 1'b0;
    modelReset();
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      checkOutput("rst_gnt", 32'({core_gnt, host_gnt}), 32'h0);
      checkOutput("rst_rvalid", 32'({core_rvalid, host_rvalid}), 32'h0);
      checkOutput("rst_rdata", {core_rdata, host_rdata}, 32'h0);
      checkOutput("rst_mem", 32'({mem_en, mem_we}), 32'h0);
      checkOutput("rst_mem_bus", {mem_addr, mem_wdata}, 32'h0);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Run the scenarios, then print the summary line.
  initial begin
    modelReset();
    pulseReset(2);

    $display("[TB] core write then read at 0x0010");
    applyStimulus(1, 1, 0, 16'h0010, 16'h1234, 0, 0, 0, 16'h0, 16'h0);
    applyStimulus(1, 0, 0, 16'h0010, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);

    $display("[TB] contended back-to-back reads");
    applyStimulus(1, 1, 0, 16'h0001, 16'hA5A5, 0, 0, 0, 16'h0, 16'h0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 1, 1, 0, 16'h0002, 16'h5A5A);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 16'h0001, 16'h0, 1, 0, 0, 16'h0002, 16'h0);
    end
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);

    $display("[TB] host write then core read at 0x0040");
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 1, 1, 0, 16'h0040, 16'hBEEF);
    applyStimulus(1, 0, 0, 16'h0040, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);

    $display("[TB] reset during a pending host read");
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 16'h0040, 16'h0);
    pulseReset(1);
    applyStimulus(1, 0, 0, 16'h0001, 16'h0, 1, 0, 0, 16'h0002, 16'h0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);

    $display("[TB] host locked stream against a busy core");
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 1, 0, 1, 16'h0003, 16'h0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 0, 0, 16'h0001, 16'h0, 1, 0, 1, 16'h0003, 16'h0);
    end
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                    16'($urandom_range(0, 15)), 16'($urandom),
                    $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                    16'($urandom_range(0, 15)), 16'($urandom));
    end
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the single-port data memory. Shares the memory between the processor core's data port (driven by the control unit's `dmem_read`/`dmem_write` sequencing) and the host loader port used to load input images and read back results. Single-cycle transfers, round-robin fairness, one-cycle read-response routing back to the requester that issued the read.

## Interface
- `DATA_W`, 16, data word width
- `ADDR_W`, 16, memory word-address width
- `MAX_BURST`, 16, maximum consecutive locked grants per owner; used only when `DMEM_ARB_BURST_EN` is defined; legal range 2..255

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `core_req`, `host_req`  in  1  transfer request, held until granted
- `core_we`, `host_we`  in  1  1 = write, 0 = read
- `core_lock`, `host_lock`  in  1  burst-hold hint
- `core_addr`, `host_addr`  in  ADDR_W  word address
- `core_wdata`, `host_wdata`  in  DATA_W  write data
- `core_gnt`, `host_gnt`  out  1  request accepted this cycle
- `core_rvalid`, `host_rvalid`  out  1  read data valid
- `core_rdata`, `host_rdata`  out  DATA_W  read data
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, registered by the memory, valid one cycle after `mem_en & ~mem_we`

## Operation
- Owner FSM with three states:
  - `IDLE`: no grant last cycle.
  - `OWN_CORE`: last grant went to the core.
  - `OWN_HOST`: last grant went to the host.
- Reset state is `IDLE`. The last-winner pointer resets to HOST, so the core wins the first tie.
- Arbitration is combinational from the current requests and the registered state:
  - Single requester: it is granted.
  - Both requesting: the requester that is not the last winner is granted.
  - No request: no grant; next state is `IDLE`. The last-winner pointer is kept.
- A transfer occurs in a cycle when `x_req & x_gnt`. At most one grant per cycle; grants are mutually exclusive.
- `mem_en = core_gnt | host_gnt`. `mem_we`, `mem_addr` and `mem_wdata` are muxed from the winner.
- When `mem_en = 0`, `mem_we`, `mem_addr` and `mem_wdata` are driven to 0.
- Read response tracking:
  - A registered `rsp_valid` and `rsp_id` capture a read grant.
  - The next cycle, the matching `x_rvalid` is 1 and `x_rdata = mem_rdata`.
  - The other requester's `rdata` is 0.
  - A write grant produces no `rvalid`.
- Back-to-back reads from alternating requesters each get their own response, one cycle after their grant. The response path is fully pipelined.

## Timing
- Grant latency is 0 cycles: `gnt` is asserted in the same cycle `req` is seen if the requester wins.
- Read latency is 1 cycle from grant to `rvalid`.
- Throughput is 1 transfer per cycle.
- Under contention without lock, each requester waits at most 1 cycle.
- Reset values:
  - All `gnt`, `rvalid`, `rdata` and `mem_*` outputs are 0.
  - `rsp_valid` = 0, burst count = 0.
- Reset asserted mid-read: the pending `rvalid` is dropped and never appears after reset is released.
- A request withdrawn before grant is legal; no state changes.

## Configuration
- `DMEM_ARB_BURST_EN` defined: burst hold is enabled.
  - If the current owner presents `req & lock` and its burst count is below `MAX_BURST`, it keeps the grant even when the other requester is asking.
  - The count increments per locked grant.
  - At `MAX_BURST` the grant is forced to the other requester if it is requesting. The count resets on any owner change or whenever lock is deasserted.
- `DMEM_ARB_BURST_EN` not defined:
  - The `lock` inputs are ignored.
  - No burst counter is built.
  - Pure alternating round-robin applies.

## Structure
- Package `dmem_arb_pkg` holds:
  - the owner-state enum (`IDLE`, `OWN_CORE`, `OWN_HOST`);
  - requester ID constants `REQ_CORE = 1'b0` and `REQ_HOST = 1'b1`;
  - the default for `MAX_BURST`.
- One sub-module, `dmem_arb_rsp_track`, holds the `rsp_valid`/`rsp_id` register and the `rvalid`/`rdata` demux.
- Arbitration, FSM and memory mux stay in the top level.

## Test plan
- Core only, write 0x1234 to 0x0010, then read 0x0010:
  - `core_gnt` asserts in both request cycles;
  - `core_rvalid` = 1 with `core_rdata` = 0x1234 one cycle after the read grant;
  - `host_rvalid` stays 0.
- Both requesting reads continuously, core at 0x0001, host at 0x0002:
  - grants go core, host, core, host;
  - each `rvalid` arrives on the correct side one cycle after its grant.
- Host write in cycle N and core read in cycle N+1 of the same address 0x0040, host data 0xBEEF:
  - core reads 0xBEEF.
- Reset pulsed low in the cycle after a host read grant:
  - `host_rvalid` stays 0;
  - after release, the first contended grant goes to the core.
- With `DMEM_ARB_BURST_EN` and `MAX_BURST` = 4: host holds `req & lock`, core requests continuously:
  - host gets 4 consecutive grants, then the core gets 1, then the host resumes.
- Without `DMEM_ARB_BURST_EN`, the same stimulus gives strict alternation.
